// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one udp_tx between NUM_SRC requesters.
// A granted source passes its UDP header, then its payload through to tlast.
module udp_tx_arbiter #(
  parameter  int NUM_SRC        = 2,
  parameter  int AXI_DATA_WIDTH = 8,
  localparam int SEL_W          = $clog2(NUM_SRC)
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [NUM_SRC-1:0]                s_udp_hdr_tvalid,
  output logic [NUM_SRC-1:0]                s_udp_hdr_trdy,
  input  logic [16*NUM_SRC-1:0]             s_udp_src_port,
  input  logic [16*NUM_SRC-1:0]             s_udp_dst_port,
  input  logic [16*NUM_SRC-1:0]             s_udp_hdr_checksum,
  input  logic [AXI_DATA_WIDTH*NUM_SRC-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                s_axis_tlast,
  output logic [NUM_SRC-1:0]                s_axis_trdy,
  output logic                              m_udp_hdr_tvalid,
  input  logic                              m_udp_hdr_trdy,
  output logic [15:0]                       m_udp_src_port,
  output logic [15:0]                       m_udp_dst_port,
  output logic [15:0]                       m_udp_hdr_checksum,
  output logic [AXI_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_trdy,
  output logic [SEL_W-1:0]                  o_grant,
  output logic                              o_busy
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t           state;
  logic [SEL_W-1:0] last_grant;
  int               gidx;
  logic             hdr_hs;
  logic             last_hs;

  // First requester after 'last' in circular order; source 0 wins when last = NUM_SRC-1.
  function automatic logic [SEL_W-1:0] pick_next(input logic [NUM_SRC-1:0] req,
                                                 input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        sel   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign gidx    = int'(o_grant);
  assign hdr_hs  = (state == HDR) && s_udp_hdr_tvalid[gidx] && m_udp_hdr_trdy;
  assign last_hs = (state == PAYLOAD) && s_axis_tvalid[gidx] && s_axis_tlast[gidx] && m_axis_trdy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_grant    <= '0;
      last_grant <= SEL_W'(NUM_SRC - 1);
      o_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_udp_hdr_tvalid) begin
            o_grant <= pick_next(s_udp_hdr_tvalid, last_grant);
            state   <= HDR;
            o_busy  <= 1'b1;
          end
        end
        HDR: begin
          if (hdr_hs) state <= PAYLOAD;
        end
        PAYLOAD: begin
          // Rotation only advances once the whole packet has been accepted.
          if (last_hs) begin
            last_grant <= o_grant;
            state      <= IDLE;
            o_busy     <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Pure combinational steering: the granted source sees the downstream ready, nobody else does.
  always_comb begin
    s_udp_hdr_trdy     = '0;
    s_axis_trdy        = '0;
    m_udp_hdr_tvalid   = 1'b0;
    m_axis_tvalid      = 1'b0;
    m_udp_src_port     = s_udp_src_port[gidx*16 +: 16];
    m_udp_dst_port     = s_udp_dst_port[gidx*16 +: 16];
    m_udp_hdr_checksum = s_udp_hdr_checksum[gidx*16 +: 16];
    m_axis_tdata       = s_axis_tdata[gidx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    m_axis_tlast       = s_axis_tlast[gidx];
    case (state)
      HDR: begin
        m_udp_hdr_tvalid     = s_udp_hdr_tvalid[gidx];
        s_udp_hdr_trdy[gidx] = m_udp_hdr_trdy;
      end
      PAYLOAD: begin
        m_axis_tvalid     = s_axis_tvalid[gidx];
        s_axis_trdy[gidx] = m_axis_trdy;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: 2-source and 4-source instances driven by a small
// per-source packet model; every header and payload beat is compared against that model.
`timescale 1ns/1ps
module tb_udp_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]  h_v2, h_tr2, av2, al2, atr2;
  logic [31:0] sp2, dp2, ck2;
  logic [15:0] ad2;
  logic        mhv2, mav2, mal2, busy2;
  logic [15:0] msp2, mdp2, mck2;
  logic [7:0]  mad2;
  logic [0:0]  g2;

  logic [3:0]  h_v4, h_tr4, av4, al4, atr4;
  logic [63:0] sp4, dp4, ck4;
  logic [31:0] ad4;
  logic        mhv4, mav4, mal4, busy4;
  logic [15:0] msp4, mdp4, mck4;
  logic [7:0]  mad4;
  logic [1:0]  g4;

  logic mh_trdy, ma_trdy;

  udp_tx_arbiter #(.NUM_SRC(2), .AXI_DATA_WIDTH(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .s_udp_hdr_tvalid(h_v2), .s_udp_hdr_trdy(h_tr2),
    .s_udp_src_port(sp2), .s_udp_dst_port(dp2), .s_udp_hdr_checksum(ck2),
    .s_axis_tdata(ad2), .s_axis_tvalid(av2), .s_axis_tlast(al2), .s_axis_trdy(atr2),
    .m_udp_hdr_tvalid(mhv2), .m_udp_hdr_trdy(mh_trdy),
    .m_udp_src_port(msp2), .m_udp_dst_port(mdp2), .m_udp_hdr_checksum(mck2),
    .m_axis_tdata(mad2), .m_axis_tvalid(mav2), .m_axis_tlast(mal2), .m_axis_trdy(ma_trdy),
    .o_grant(g2), .o_busy(busy2)
  );

  udp_tx_arbiter #(.NUM_SRC(4), .AXI_DATA_WIDTH(8)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n),
    .s_udp_hdr_tvalid(h_v4), .s_udp_hdr_trdy(h_tr4),
    .s_udp_src_port(sp4), .s_udp_dst_port(dp4), .s_udp_hdr_checksum(ck4),
    .s_axis_tdata(ad4), .s_axis_tvalid(av4), .s_axis_tlast(al4), .s_axis_trdy(atr4),
    .m_udp_hdr_tvalid(mhv4), .m_udp_hdr_trdy(mh_trdy),
    .m_udp_src_port(msp4), .m_udp_dst_port(mdp4), .m_udp_hdr_checksum(mck4),
    .m_axis_tdata(mad4), .m_axis_tvalid(mav4), .m_axis_tlast(mal4), .m_axis_trdy(ma_trdy),
    .o_grant(g4), .o_busy(busy4)
  );

  // Source model: st 0=idle, 1=presenting header, 2=sending payload beat cnt.
  int st[4], cnt[4], pk[4], npk[4], len[4];
  bit go[4], hhs[4], dhs[4];
  int sel, rnd, trig3, cyc, nchk, npass, viol, nbytes, last_cyc;
  bit prev_mh;
  int gq[$];
  int gaps[$];

  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int exp_byte(input int k, input int p, input int c);
    return (k % 4) * 64 + (p % 4) * 16 + (c % 16);
  endfunction

  function automatic int exp_word(input int base, input int k, input int p);
    return (base + k * 256 + p) & 'hffff;
  endfunction

  function automatic bit idle_all();
    bit r;
    r = 1'b1;
    for (int i = 0; i < 4; i++) if (npk[i] != 0 || st[i] != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drive();
    h_v2 = '0; av2 = '0; al2 = '0; ad2 = '0; sp2 = '0; dp2 = '0; ck2 = '0;
    h_v4 = '0; av4 = '0; al4 = '0; ad4 = '0; sp4 = '0; dp4 = '0; ck4 = '0;
    for (int i = 0; i < 4; i++) begin
      bit hv, v, l;
      int d, s, t, c;
      hv = (st[i] == 1);
      v  = (st[i] == 2);
      l  = v && (cnt[i] == len[i] - 1);
      d  = exp_byte(i, pk[i], cnt[i]);
      s  = exp_word('h1234, i, pk[i]);
      t  = exp_word('h5678, i, pk[i]);
      c  = exp_word(0, i, pk[i]);
      if (sel == 0 && i < 2) begin
        h_v2[i] = hv; av2[i] = v; al2[i] = l; ad2[8*i +: 8] = 8'(d);
        sp2[16*i +: 16] = 16'(s); dp2[16*i +: 16] = 16'(t); ck2[16*i +: 16] = 16'(c);
      end else if (sel == 1) begin
        h_v4[i] = hv; av4[i] = v; al4[i] = l; ad4[8*i +: 8] = 8'(d);
        sp4[16*i +: 16] = 16'(s); dp4[16*i +: 16] = 16'(t); ck4[16*i +: 16] = 16'(c);
      end
    end
  endtask

  task automatic monitor();
    logic [3:0] htr, atr;
    bit mhv, mav, mal;
    int msp, mdp, mck, mad, g, nh, nd, k, kd;
    if (sel == 0) begin
      htr = {2'b00, h_tr2}; atr = {2'b00, atr2}; mhv = mhv2; mav = mav2; mal = mal2;
      msp = int'(msp2); mdp = int'(mdp2); mck = int'(mck2); mad = int'(mad2); g = int'(g2);
    end else begin
      htr = h_tr4; atr = atr4; mhv = mhv4; mav = mav4; mal = mal4;
      msp = int'(msp4); mdp = int'(mdp4); mck = int'(mck4); mad = int'(mad4); g = int'(g4);
    end
    nh = 0; nd = 0; k = -1; kd = -1;
    for (int i = 0; i < 4; i++) begin
      if (st[i] == 1 && htr[i]) begin hhs[i] = 1'b1; nh++; k = i; end
      if (st[i] == 2 && atr[i]) begin dhs[i] = 1'b1; nd++; kd = i; end
      if ((htr[i] || atr[i]) && i != g) viol++;
    end
    if (nh > 1 || nd > 1) viol++;
    if (mhv && mh_trdy) begin
      chk("hdr_owner", nh, 1);
      if (nh == 1) begin
        chk("hdr_grant", g, k);
        chk("hdr_src", msp, exp_word('h1234, k, pk[k]));
        chk("hdr_dst", mdp, exp_word('h5678, k, pk[k]));
        chk("hdr_csum", mck, exp_word(0, k, pk[k]));
        gq.push_back(k);
      end
    end else if (nh != 0) chk("hdr_noxfer", nh, 0);
    if (mav && ma_trdy) begin
      chk("dat_owner", nd, 1);
      if (nd == 1) begin
        chk("dat_byte", mad, exp_byte(kd, pk[kd], cnt[kd]));
        chk("dat_last", int'(mal), int'(cnt[kd] == len[kd] - 1));
        nbytes++;
        if (mal) last_cyc = cyc;
      end
    end else if (nd != 0) chk("dat_noxfer", nd, 0);
    if (mhv && !prev_mh && last_cyc >= 0) gaps.push_back(cyc - last_cyc);
    prev_mh = mhv;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (hhs[i]) begin st[i] = 2; cnt[i] = 0; end
      else if (dhs[i]) begin
        if (cnt[i] == len[i] - 1) begin st[i] = 0; npk[i]--; pk[i]++; end
        else cnt[i]++;
      end
      hhs[i] = 1'b0; dhs[i] = 1'b0;
    end
    if (trig3 != 0 && st[0] == 2 && cnt[0] == 3) go[1] = 1'b1;
    for (int i = 0; i < 4; i++) if (st[i] == 0 && npk[i] > 0 && go[i]) st[i] = 1;
    drive();
    mh_trdy = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    ma_trdy = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    monitor();
  endtask

  task automatic reset_all(input int s);
    rst_n = 1'b0; sel = s; rnd = 0; trig3 = 0;
    for (int i = 0; i < 4; i++) begin
      st[i] = 0; cnt[i] = 0; pk[i] = 0; npk[i] = 0; len[i] = 1;
      go[i] = 1'b0; hhs[i] = 1'b0; dhs[i] = 1'b0;
    end
    gq.delete(); gaps.delete();
    nbytes = 0; last_cyc = -1; prev_mh = 1'b0; viol = 0;
    step(); step();
    chk("rst_busy2", int'(busy2), 0);
    chk("rst_grant2", int'(g2), 0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_grant4", int'(g4), 0);
    chk("rst_vld", int'({mhv2, mav2, mhv4, mav4, h_tr2, atr2, h_tr4, atr4}), 0);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic run_done(input string tag, input int bound);
    int n;
    n = 0;
    while (!idle_all() && n < bound) begin step(); n++; end
    chk(tag, int'(n < bound), 1);
    repeat (3) step();
  endtask

  // Expected grant order packed one hex digit per grant, first grant in the top digit.
  task automatic chk_order(input string tag, input int n, input int code);
    chk({tag, "_n"}, gq.size(), n);
    for (int k = 0; k < n; k++)
      chk(tag, (k < gq.size()) ? gq[k] : -1, (code >> (4 * (n - 1 - k))) & 15);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; mh_trdy = 1'b1; ma_trdy = 1'b1;

    // Single source, 8-byte payload.
    reset_all(0);
    npk[0] = 1; len[0] = 8; go[0] = 1'b1;
    run_done("t1_done", 100);
    chk_order("t1_order", 1, 'h0);
    chk("t1_bytes", nbytes, 8);
    chk("t1_viol", viol, 0);

    // Both sources saturating: strict alternation with a one-cycle idle gap.
    reset_all(0);
    npk[0] = 4; npk[1] = 4; len[0] = 3; len[1] = 2; go[0] = 1'b1; go[1] = 1'b1;
    run_done("t2_done", 200);
    chk_order("t2_order", 8, 'h01010101);
    chk("t2_bytes", nbytes, 20);
    chk("t2_ngap", gaps.size(), 7);
    foreach (gaps[k]) chk("t2_gap", gaps[k], 2);
    chk("t2_viol", viol, 0);

    // Source 1 requests during byte 3 of a 16-byte packet from source 0.
    reset_all(0);
    npk[0] = 1; len[0] = 16; npk[1] = 1; len[1] = 2; go[0] = 1'b1; trig3 = 1;
    run_done("t3_done", 200);
    chk_order("t3_order", 2, 'h01);
    chk("t3_gap", (gaps.size() > 0) ? gaps[0] : -1, 2);
    chk("t3_bytes", nbytes, 18);
    chk("t3_viol", viol, 0);

    // Random downstream backpressure.
    reset_all(0);
    rnd = 1;
    npk[0] = 3; npk[1] = 3; len[0] = 5; len[1] = 5; go[0] = 1'b1; go[1] = 1'b1;
    run_done("t4_done", 2000);
    chk_order("t4_order", 6, 'h010101);
    chk("t4_bytes", nbytes, 30);
    chk("t4_viol", viol, 0);

    // Reset in the middle of source 0's second packet, source 1 waiting.
    reset_all(0);
    npk[0] = 2; len[0] = 10; npk[1] = 1; len[1] = 10; go[0] = 1'b1;
    n = 0;
    while (!(pk[0] == 1 && st[0] >= 1) && n < 200) begin step(); n++; end
    chk("t5_reach1", int'(n < 200), 1);
    go[1] = 1'b1;
    n = 0;
    while (!(pk[0] == 1 && st[0] == 2 && cnt[0] == 3) && n < 200) begin step(); n++; end
    chk("t5_reach2", int'(n < 200), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", int'(busy2), 0);
    chk("t5_vld", int'({mhv2, mav2, h_tr2, atr2}), 0);
    for (int i = 0; i < 4; i++) begin
      if (st[i] == 2) begin st[i] = 1; cnt[i] = 0; end
      hhs[i] = 1'b0; dhs[i] = 1'b0;
    end
    gq.delete(); nbytes = 0; last_cyc = -1;
    step(); step();
    chk("t5_grant_rst", int'(g2), 0);
    #1 rst_n = 1'b1;
    run_done("t5_done", 300);
    chk_order("t5_order", 2, 'h01);
    chk("t5_bytes", nbytes, 20);
    chk("t5_viol", viol, 0);

    // Four-source instance, sources 1 and 3 with single-beat packets.
    reset_all(1);
    npk[1] = 2; npk[3] = 2; len[1] = 1; len[3] = 1;
    for (int i = 0; i < 4; i++) go[i] = 1'b1;
    run_done("t6_done", 200);
    chk_order("t6_order", 4, 'h1313);
    chk("t6_bytes", nbytes, 4);
    chk("t6_viol", viol, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
